// File: rtl/pdl_buffer_if.sv
// PDL buffer bus: control strobes, addresses and data between PDL control,
// the datapath and the PDL buffer.
interface pdl_buffer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              state_read;
  logic              state_write;
  logic [ADDR_W-1:0] pdla;
  logic              pwp;
  logic              prp;
  logic              pdlcnt;
  logic              destpdl_p;
  logic              pdldrive;
  logic              ldpdlptr;
  logic              ldpdlidx;
  logic [ADDR_W-1:0] ob;
  logic [DATA_W-1:0] l;
  logic [ADDR_W-1:0] pdlptr;
  logic [ADDR_W-1:0] pdlidx;
  logic [DATA_W-1:0] pdlout;
  logic              pdl_wrap;

  // Control/datapath side.
  modport master (
    output state_read, state_write, pdla, pwp, prp, pdlcnt, destpdl_p,
           pdldrive, ldpdlptr, ldpdlidx, ob, l,
    input  pdlptr, pdlidx, pdlout, pdl_wrap
  );

  // PDL buffer side.
  modport slave (
    input  state_read, state_write, pdla, pwp, prp, pdlcnt, destpdl_p,
           pdldrive, ldpdlptr, ldpdlidx, ob, l,
    output pdlptr, pdlidx, pdlout, pdl_wrap
  );
endinterface

// File: rtl/pdl_buffer.sv
// PDL buffer: push-down-list RAM, read register, PDL pointer and index
// registers, and the sticky pointer-wrap flag.
module pdl_buffer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic        clk,
  input logic        reset,
  pdl_buffer_if.slave bus
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              wrap_q, wrap_d;

  // The read decision is made by control; state_read carries no extra meaning here.
  logic unused_state_read;
  assign unused_state_read = bus.state_read;

  // Next-state: read register with write-first bypass, pointer load/count, index load.
  always_comb begin
    rd_d   = rd_q;
    ptr_d  = ptr_q;
    idx_d  = idx_q;
    wrap_d = wrap_q;

    if (bus.prp) begin
      // pwp and prp share pdla, so a simultaneous pair always collides.
      rd_d = bus.pwp ? bus.l : mem[bus.pdla];
    end

    if (bus.ldpdlptr) begin
      ptr_d  = bus.ob;
      wrap_d = 1'b0;
    end else if (bus.state_write && bus.pdlcnt) begin
      if (bus.destpdl_p) begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) wrap_d = 1'b1;
      end else begin
        ptr_d = ptr_q - 1'b1;
        if (ptr_q == '0) wrap_d = 1'b1;
      end
    end

    if (bus.ldpdlidx) begin
      idx_d = bus.ob;
    end
  end

  // Register update; RAM is not cleared, but no write lands while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q   <= '0;
      ptr_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      if (bus.pwp) begin
        mem[bus.pdla] <= bus.l;
      end
    end
  end

  // Output gating onto the M-source mux.
  always_comb begin
    bus.pdlout   = bus.pdldrive ? rd_q : '0;
    bus.pdlptr   = ptr_q;
    bus.pdlidx   = idx_q;
    bus.pdl_wrap = wrap_q;
  end

endmodule

// File: tb/tb_pdl_buffer.sv
// Bench for pdl_buffer: pointer vector table, hand-written RAM/reset
// sequences, then random traffic against a behavioural model.
module tb_pdl_buffer;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;

  pdl_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pdl_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  int          m_ptr, m_idx;
  bit          m_wrap;
  logic [31:0] m_rd;
  bit          m_rd_known;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

  typedef struct {
    bit         sw, cnt, dir, ldp, ldi;
    logic [9:0] ob;
    logic [9:0] e_ptr, e_idx;
    bit         e_wrap;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(bit sw, bit cnt, bit dir, bit ldp, bit ldi,
                              logic [9:0] ob, logic [9:0] e_ptr,
                              logic [9:0] e_idx, bit e_wrap);
    vec_t v;
    v.sw = sw; v.cnt = cnt; v.dir = dir; v.ldp = ldp; v.ldi = ldi;
    v.ob = ob; v.e_ptr = e_ptr; v.e_idx = e_idx; v.e_wrap = e_wrap;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.state_read = 0; bus.state_write = 0; bus.pdla = '0; bus.pwp = 0;
    bus.prp = 0; bus.pdlcnt = 0; bus.destpdl_p = 0; bus.pdldrive = 0;
    bus.ldpdlptr = 0; bus.ldpdlidx = 0; bus.ob = '0; bus.l = '0;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_idx = 0; m_wrap = 0; m_rd = '0; m_rd_known = 1;
  endtask

  // What one clock edge should do, from the current inputs.
  task automatic model_edge();
    int raw;
    int a;
    if (reset) return;
    a = int'(bus.pdla);
    if (bus.prp) begin
      if (bus.pwp) begin
        m_rd = bus.l; m_rd_known = 1;
      end else begin
        m_rd = m_mem[a]; m_rd_known = m_known[a];
      end
    end
    if (bus.pwp) begin
      m_mem[a] = bus.l; m_known[a] = 1;
    end
    if (bus.ldpdlptr) begin
      m_ptr = int'(bus.ob); m_wrap = 0;
    end else if (bus.state_write && bus.pdlcnt) begin
      raw = m_ptr + (bus.destpdl_p ? 1 : -1);
      if (raw < 0 || raw >= DEPTH) m_wrap = 1;
      m_ptr = (raw + DEPTH) % DEPTH;
    end
    if (bus.ldpdlidx) m_idx = int'(bus.ob);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ptr"}, 32'(bus.pdlptr), 32'(m_ptr));
    check({tag, "_idx"}, 32'(bus.pdlidx), 32'(m_idx));
    check({tag, "_wrap"}, 32'(bus.pdl_wrap), 32'(m_wrap));
    if (m_rd_known)
      check({tag, "_out"}, bus.pdlout, bus.pdldrive ? m_rd : 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0; m_known[i] = 0;
    end
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    bus.pdldrive = 1;
    #1;
    check("rst_ptr", 32'(bus.pdlptr), 32'h0);
    check("rst_idx", 32'(bus.pdlidx), 32'h0);
    check("rst_out", bus.pdlout, 32'h0);
    check("rst_wrap", 32'(bus.pdl_wrap), 32'h0);
    bus.pdldrive = 0;

    // Pointer / index vector table
    tbl[0]  = mk(0, 0, 0, 1, 0, 10'h3FE, 10'h3FE, 10'h000, 0);
    tbl[1]  = mk(1, 1, 1, 0, 0, 10'h000, 10'h3FF, 10'h000, 0);
    tbl[2]  = mk(1, 1, 1, 0, 0, 10'h000, 10'h000, 10'h000, 1);
    tbl[3]  = mk(1, 1, 0, 0, 0, 10'h000, 10'h3FF, 10'h000, 1);
    tbl[4]  = mk(0, 0, 0, 1, 0, 10'h010, 10'h010, 10'h000, 0);
    tbl[5]  = mk(0, 0, 0, 1, 0, 10'h000, 10'h000, 10'h000, 0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 10'h000, 10'h3FF, 10'h000, 1);
    tbl[7]  = mk(0, 1, 0, 0, 0, 10'h000, 10'h3FF, 10'h000, 1);
    tbl[8]  = mk(1, 1, 1, 1, 0, 10'h100, 10'h100, 10'h000, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 10'h055, 10'h100, 10'h055, 0);
    tbl[10] = mk(1, 1, 1, 0, 1, 10'h2AA, 10'h101, 10'h2AA, 0);
    for (int i = 0; i < 11; i++) begin
      idle();
      bus.state_write = tbl[i].sw; bus.pdlcnt = tbl[i].cnt;
      bus.destpdl_p = tbl[i].dir; bus.ldpdlptr = tbl[i].ldp;
      bus.ldpdlidx = tbl[i].ldi; bus.ob = tbl[i].ob;
      tick();
      check($sformatf("tbl%0d_ptr", i), 32'(bus.pdlptr), 32'(tbl[i].e_ptr));
      check($sformatf("tbl%0d_idx", i), 32'(bus.pdlidx), 32'(tbl[i].e_idx));
      check($sformatf("tbl%0d_wrap", i), 32'(bus.pdl_wrap), 32'(tbl[i].e_wrap));
    end

    // Write then read, gated output
    idle(); bus.pwp = 1; bus.pdla = 10'h012; bus.l = 32'h12345678;
    tick();
    idle(); bus.prp = 1; bus.pdla = 10'h012; bus.pdldrive = 1;
    tick();
    check("wr_rd_out", bus.pdlout, 32'h12345678);
    idle(); bus.pdldrive = 0;
    #1;
    check("rd_gated", bus.pdlout, 32'h0);
    bus.pdldrive = 1;
    #1;
    check("rd_hold", bus.pdlout, 32'h12345678);

    // Collision bypass, then independent write/read at neighbouring words
    idle(); bus.pwp = 1; bus.prp = 1; bus.pdla = 10'h020; bus.l = 32'hCAFEF00D; bus.pdldrive = 1;
    tick();
    check("coll_bypass", bus.pdlout, 32'hCAFEF00D);
    idle(); bus.pwp = 1; bus.pdla = 10'h021; bus.l = 32'h5555AAAA; bus.pdldrive = 1;
    tick();
    idle(); bus.prp = 1; bus.pdla = 10'h020; bus.pdldrive = 1;
    tick();
    check("coll_old20", bus.pdlout, 32'hCAFEF00D);
    idle(); bus.prp = 1; bus.pdla = 10'h021; bus.pdldrive = 1;
    tick();
    check("coll_new21", bus.pdlout, 32'h5555AAAA);

    // Reset mid-write aborts the write and clears registers at once
    idle(); bus.pwp = 1; bus.pdla = 10'h005; bus.l = 32'h11111111;
    tick();
    idle(); bus.ldpdlptr = 1; bus.ldpdlidx = 1; bus.ob = 10'h02A;
    tick();
    idle(); bus.pwp = 1; bus.pdla = 10'h005; bus.l = 32'h0000DEAD; bus.pdldrive = 1;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_ptr", 32'(bus.pdlptr), 32'h0);
    check("arst_idx", 32'(bus.pdlidx), 32'h0);
    check("arst_out", bus.pdlout, 32'h0);
    tick();
    reset = 1'b0;
    idle(); bus.prp = 1; bus.pdla = 10'h005; bus.pdldrive = 1;
    tick();
    check("arst_nowrite", bus.pdlout, 32'h11111111);

    // Random traffic over a small address window against the model
    for (int a = 0; a < 16; a++) begin
      idle(); bus.pwp = 1; bus.pdla = 10'(a); bus.l = $urandom;
      tick();
    end
    for (int i = 0; i < 400; i++) begin
      idle();
      bus.pdla        = 10'($urandom_range(0, 15));
      bus.pwp         = ($urandom_range(0, 2) == 0);
      bus.prp         = ($urandom_range(0, 1) == 0);
      bus.l           = $urandom;
      bus.pdldrive    = ($urandom_range(0, 3) != 0);
      bus.state_write = ($urandom_range(0, 3) != 0);
      bus.state_read  = ~bus.state_write;
      bus.pdlcnt      = ($urandom_range(0, 1) == 0);
      bus.destpdl_p   = ($urandom_range(0, 1) == 0);
      bus.ldpdlptr    = ($urandom_range(0, 15) == 0);
      bus.ldpdlidx    = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       bus.ob = '0;
        1:       bus.ob = '1;
        default: bus.ob = 10'($urandom);
      endcase
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
